// File: rtl/kernel_svm_credit_limiter.sv
// kernel_svm_credit_limiter: throttles outstanding read beats and write bursts on the kernel
// USM host-memory channel. Write throttling happens only at burst starts. Provides a
// registered idle indication and a sticky protocol-error flag.
// Optional: define KERNEL_SVM_CREDIT_LIMITER_STATS_EN to add throttle stall-cycle counters.
module kernel_svm_credit_limiter #(
  parameter int unsigned ADDR_WIDTH      = 48,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned BURST_CNT_WIDTH = 5,
  parameter int unsigned MAX_RD_BEATS    = 256,
  parameter int unsigned MAX_WR_BURSTS   = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ADDR_WIDTH-1:0]      s_address,
  input  logic                       s_read,
  input  logic                       s_write,
  input  logic [BURST_CNT_WIDTH-1:0] s_burstcount,
  input  logic [DATA_WIDTH-1:0]      s_writedata,
  input  logic [DATA_WIDTH/8-1:0]    s_byteenable,
  output logic                       s_waitrequest,
  output logic [DATA_WIDTH-1:0]      s_readdata,
  output logic                       s_readdatavalid,
  output logic                       s_writeresponsevalid,
  output logic [ADDR_WIDTH-1:0]      m_address,
  output logic                       m_read,
  output logic                       m_write,
  output logic [BURST_CNT_WIDTH-1:0] m_burstcount,
  output logic [DATA_WIDTH-1:0]      m_writedata,
  output logic [DATA_WIDTH/8-1:0]    m_byteenable,
  input  logic                       m_waitrequest,
  input  logic [DATA_WIDTH-1:0]      m_readdata,
  input  logic                       m_readdatavalid,
  input  logic                       m_writeresponsevalid,
  output logic                       idle,
`ifdef KERNEL_SVM_CREDIT_LIMITER_STATS_EN
  output logic [31:0]                rd_stall_cycles,
  output logic [31:0]                wr_stall_cycles,
`endif
  output logic                       protocol_err
);

  localparam int unsigned MaxBurst = 1 << (BURST_CNT_WIDTH - 1);
  localparam int unsigned RdCntW   = $clog2(MAX_RD_BEATS + 1);
  localparam int unsigned WrCntW   = $clog2(MAX_WR_BURSTS + 1);
  // A read is admitted only if a maximum-length burst still fits under the limit.
  localparam logic [RdCntW-1:0] RdFullTh = RdCntW'(MAX_RD_BEATS - MaxBurst);
  localparam logic [WrCntW-1:0] WrMax    = WrCntW'(MAX_WR_BURSTS);

  typedef enum logic [0:0] {StWrIdle, StWrBurst} wr_state_e;

  wr_state_e                  wr_state_q, wr_state_d;
  logic [RdCntW-1:0]          rd_cnt_q, rd_cnt_d;
  logic [WrCntW-1:0]          wr_cnt_q, wr_cnt_d;
  logic [BURST_CNT_WIDTH-1:0] beats_left_q, beats_left_d;
  logic                       idle_q, err_q, err_d;
  logic rd_full, wr_full, first_beat, rd_blk, wr_blk, blk;
  logic rd_acc, wr_acc, rd_ret, wr_ret, err_evt;

  assign rd_full    = rd_cnt_q > RdFullTh;
  assign wr_full    = wr_cnt_q == WrMax;
  assign first_beat = wr_state_q == StWrIdle;

  assign rd_blk = s_read & rd_full;
  assign wr_blk = s_write & first_beat & wr_full;
  assign blk    = rd_blk | wr_blk;

  // Reset gates the command path so nothing escapes while state is being discarded.
  assign s_waitrequest = m_waitrequest | blk | ~reset_n;
  assign m_read        = s_read & ~blk & reset_n;
  assign m_write       = s_write & ~blk & reset_n;
  assign m_address     = s_address;
  assign m_burstcount  = s_burstcount;
  assign m_writedata   = s_writedata;
  assign m_byteenable  = s_byteenable;

  assign s_readdata           = m_readdata;
  assign s_readdatavalid      = m_readdatavalid;
  assign s_writeresponsevalid = m_writeresponsevalid;

  assign rd_acc = s_read & ~s_waitrequest;
  assign wr_acc = s_write & ~s_waitrequest;
  // Returns on an empty counter are errors and do not decrement (saturate at 0).
  assign rd_ret = m_readdatavalid & (rd_cnt_q != '0);
  assign wr_ret = m_writeresponsevalid & (wr_cnt_q != '0);

  assign err_evt = (s_read & s_write)
                 | ((s_read | s_write) & (s_burstcount == '0))
                 | (s_read & ~first_beat)
                 | (m_readdatavalid & (rd_cnt_q == '0))
                 | (m_writeresponsevalid & (wr_cnt_q == '0));

  // Next-state: credit counters, write-burst tracker FSM and sticky error
  always_comb begin
    rd_cnt_d     = rd_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    beats_left_d = beats_left_q;
    wr_state_d   = wr_state_q;
    err_d        = err_q | err_evt;

    if (rd_acc) rd_cnt_d = rd_cnt_d + RdCntW'(s_burstcount);
    if (rd_ret) rd_cnt_d = rd_cnt_d - RdCntW'(1);

    case (wr_state_q)
      StWrIdle: begin
        if (wr_acc) begin
          wr_cnt_d = wr_cnt_d + WrCntW'(1);
          if (s_burstcount > BURST_CNT_WIDTH'(1)) begin
            beats_left_d = s_burstcount - BURST_CNT_WIDTH'(1);
            wr_state_d   = StWrBurst;
          end
        end
      end
      StWrBurst: begin
        if (wr_acc) begin
          beats_left_d = beats_left_q - BURST_CNT_WIDTH'(1);
          if (beats_left_q == BURST_CNT_WIDTH'(1)) wr_state_d = StWrIdle;
        end
      end
      default: wr_state_d = StWrIdle;
    endcase

    if (wr_ret) wr_cnt_d = wr_cnt_d - WrCntW'(1);
  end

  // State register; idle is registered from the current state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      beats_left_q <= '0;
      wr_state_q   <= StWrIdle;
      idle_q       <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      beats_left_q <= beats_left_d;
      wr_state_q   <= wr_state_d;
      idle_q       <= (rd_cnt_q == '0) & (wr_cnt_q == '0) & first_beat;
      err_q        <= err_d;
    end
  end

  assign idle         = idle_q;
  assign protocol_err = err_q;

`ifdef KERNEL_SVM_CREDIT_LIMITER_STATS_EN
  logic [31:0] rd_stall_q, wr_stall_q;

  // Count cycles stalled by the limiter itself (not by m_waitrequest), saturating
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_stall_q <= '0;
      wr_stall_q <= '0;
    end else begin
      if (rd_blk && (rd_stall_q != '1)) rd_stall_q <= rd_stall_q + 32'd1;
      if (wr_blk && (wr_stall_q != '1)) wr_stall_q <= wr_stall_q + 32'd1;
    end
  end

  assign rd_stall_cycles = rd_stall_q;
  assign wr_stall_cycles = wr_stall_q;
`endif

endmodule

// File: tb/tb_kernel_svm_credit_limiter.sv
// Self-checking bench for kernel_svm_credit_limiter: vector table, directed corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_kernel_svm_credit_limiter;
  localparam int unsigned AW       = 48;
  localparam int unsigned DW       = 512;
  localparam int unsigned BCW      = 5;
  localparam int          MaxRd    = 256;
  localparam int          MaxWr    = 64;
  localparam int          MaxBurst = 16;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [AW-1:0]  s_address, m_address;
  logic           s_read, s_write, m_read, m_write;
  logic [BCW-1:0] s_burstcount, m_burstcount;
  logic [DW-1:0]  s_writedata, m_writedata, s_readdata, m_readdata;
  logic [DW/8-1:0] s_byteenable, m_byteenable;
  logic           s_waitrequest, m_waitrequest;
  logic           s_readdatavalid, m_readdatavalid;
  logic           s_writeresponsevalid, m_writeresponsevalid;
  logic           idle, protocol_err;
`ifdef KERNEL_SVM_CREDIT_LIMITER_STATS_EN
  logic [31:0]    rd_stall_cycles, wr_stall_cycles;
`endif

  kernel_svm_credit_limiter dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .s_address            (s_address),
    .s_read               (s_read),
    .s_write              (s_write),
    .s_burstcount         (s_burstcount),
    .s_writedata          (s_writedata),
    .s_byteenable         (s_byteenable),
    .s_waitrequest        (s_waitrequest),
    .s_readdata           (s_readdata),
    .s_readdatavalid      (s_readdatavalid),
    .s_writeresponsevalid (s_writeresponsevalid),
    .m_address            (m_address),
    .m_read               (m_read),
    .m_write              (m_write),
    .m_burstcount         (m_burstcount),
    .m_writedata          (m_writedata),
    .m_byteenable         (m_byteenable),
    .m_waitrequest        (m_waitrequest),
    .m_readdata           (m_readdata),
    .m_readdatavalid      (m_readdatavalid),
    .m_writeresponsevalid (m_writeresponsevalid),
    .idle                 (idle),
`ifdef KERNEL_SVM_CREDIT_LIMITER_STATS_EN
    .rd_stall_cycles      (rd_stall_cycles),
    .wr_stall_cycles      (wr_stall_cycles),
`endif
    .protocol_err         (protocol_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: outstanding read beats, outstanding write bursts, beats still owed
  // in the current write burst, plus the observable flags.
  int          mdl_rd, mdl_wr, mdl_left;
  bit          mdl_err, mdl_idle;
  int unsigned mdl_rd_stall, mdl_wr_stall;
  logic        obs_wait, obs_mrd, obs_mwr;

  typedef struct {
    bit rd; bit wr; int unsigned bc; bit mw; bit rdv; bit wrv;
    bit e_wait; bit e_mrd; bit e_mwr;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_rd = 0; mdl_wr = 0; mdl_left = 0;
    mdl_err = 0; mdl_idle = 1; mdl_rd_stall = 0; mdl_wr_stall = 0;
  endtask

  // Hold reset for two edges with the given requests asserted; outputs must stay gated.
  task automatic do_reset(input bit rd, input bit wr);
    reset_n = 0; s_read = rd; s_write = wr; s_burstcount = 1;
    m_waitrequest = 0; m_readdatavalid = 0; m_writeresponsevalid = 0;
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_waitrequest", s_waitrequest, 1);
      check("rst_m_read", m_read, 0);
      check("rst_m_write", m_write, 0);
    end
    reset_n = 1; s_read = 0; s_write = 0;
    model_reset();
  endtask

  // One cycle: drive, check combinational and registered outputs against the model,
  // advance the model, then cross the clock edge.
  task automatic step(input bit rd, input bit wr, input int unsigned bc,
                      input bit mw, input bit rdv, input bit wrv);
    bit rd_blk, wr_blk, ew, nidle;
    int nrd, nwr;
    s_read = rd; s_write = wr; s_burstcount = BCW'(bc);
    m_waitrequest = mw; m_readdatavalid = rdv; m_writeresponsevalid = wrv;
    s_address = AW'({$urandom, $urandom});
    s_byteenable = {$urandom, $urandom};
    for (int i = 0; i < DW / 32; i++) begin
      s_writedata[i*32 +: 32] = $urandom;
      m_readdata[i*32 +: 32]  = $urandom;
    end
    #1;
    rd_blk = rd && (mdl_rd > MaxRd - MaxBurst);
    wr_blk = wr && (mdl_left == 0) && (mdl_wr == MaxWr);
    ew = mw || rd_blk || wr_blk;
    check("s_waitrequest", s_waitrequest, ew);
    check("m_read", m_read, rd && !(rd_blk || wr_blk));
    check("m_write", m_write, wr && !(rd_blk || wr_blk));
    check("idle", idle, mdl_idle);
    check("protocol_err", protocol_err, mdl_err);
    check("pass_address", m_address === s_address, 1);
    check("pass_burstcount", m_burstcount === s_burstcount, 1);
    check("pass_writedata", m_writedata === s_writedata, 1);
    check("pass_byteenable", m_byteenable === s_byteenable, 1);
    check("pass_readdata", s_readdata === m_readdata, 1);
    check("pass_readdatavalid", s_readdatavalid, rdv);
    check("pass_wrresp", s_writeresponsevalid, wrv);
`ifdef KERNEL_SVM_CREDIT_LIMITER_STATS_EN
    check("rd_stall_cycles", rd_stall_cycles, mdl_rd_stall);
    check("wr_stall_cycles", wr_stall_cycles, mdl_wr_stall);
`endif
    obs_wait = s_waitrequest; obs_mrd = m_read; obs_mwr = m_write;

    nidle = (mdl_rd == 0) && (mdl_wr == 0) && (mdl_left == 0);
    if ((rd && wr) || ((rd || wr) && bc == 0) || (rd && mdl_left > 0) ||
        (rdv && mdl_rd == 0) || (wrv && mdl_wr == 0)) mdl_err = 1;
    if (rd_blk) mdl_rd_stall++;
    if (wr_blk) mdl_wr_stall++;
    nrd = mdl_rd;
    if (rd && !ew) nrd += int'(bc);
    if (rdv && mdl_rd > 0) nrd--;
    nwr = mdl_wr;
    if (wr && !ew) begin
      if (mdl_left == 0) begin
        nwr++;
        if (bc > 1) mdl_left = int'(bc) - 1;
      end else begin
        mdl_left--;
      end
    end
    if (wrv && mdl_wr > 0) nwr--;
    mdl_rd = nrd; mdl_wr = nwr; mdl_idle = nidle;
    @(posedge clk); #1;
  endtask

  initial begin
    // rd wr bc mw rdv wrv | wait mrd mwr   (applied from a fresh reset, in order)
    vecs[0]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 4, 1, 0, 0, 1, 1, 0};
    vecs[2]  = '{1, 0, 4, 0, 0, 0, 0, 1, 0};
    vecs[3]  = '{0, 1, 2, 0, 0, 0, 0, 0, 1};
    vecs[4]  = '{0, 1, 2, 1, 0, 0, 1, 0, 1};
    vecs[5]  = '{0, 1, 2, 0, 0, 0, 0, 0, 1};
    vecs[6]  = '{0, 0, 1, 0, 1, 1, 0, 0, 0};
    vecs[7]  = '{0, 1, 1, 1, 0, 0, 1, 0, 1};
    vecs[8]  = '{0, 0, 1, 0, 1, 0, 0, 0, 0};
    vecs[9]  = '{0, 0, 1, 0, 1, 0, 0, 0, 0};
    vecs[10] = '{0, 0, 1, 0, 1, 0, 0, 0, 0};

    s_address = '0; s_writedata = '0; s_byteenable = '0; m_readdata = '0;
    model_reset();
    do_reset(0, 0);
    check("reset_idle", idle, 1);
    check("reset_protocol_err", protocol_err, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rd, vecs[i].wr, vecs[i].bc, vecs[i].mw, vecs[i].rdv, vecs[i].wrv);
      check("vec_waitrequest", obs_wait, vecs[i].e_wait);
      check("vec_m_read", obs_mrd, vecs[i].e_mrd);
      check("vec_m_write", obs_mwr, vecs[i].e_mwr);
    end
    check("vec_no_err", protocol_err, 0);

    // Read credit limit: 16 bursts of 16 accepted, then held off until count <= 240.
    do_reset(0, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 16, 0, 0, 0);
      check("rd_fill_accept", obs_wait, 0);
    end
    step(1, 0, 16, 0, 0, 0);
    check("rd_17th_stall", obs_wait, 1);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 16, 0, 1, 0);
      check("rd_stall_above_240", obs_wait, 1);
    end
    step(1, 0, 16, 0, 0, 0);
    check("rd_release_at_240", obs_wait, 0);
`ifdef KERNEL_SVM_CREDIT_LIMITER_STATS_EN
    check("rd_stall_total", rd_stall_cycles, 17);
`endif

    // Write-burst limit: 65th burst waits for a response, accepted the cycle after it.
    do_reset(0, 0);
    for (int i = 0; i < 64; i++) begin
      step(0, 1, 1, 0, 0, 0);
      check("wr_fill_accept", obs_wait, 0);
    end
    step(0, 1, 1, 0, 0, 0);
    check("wr_65th_stall", obs_wait, 1);
    step(0, 1, 1, 0, 0, 1);
    check("wr_stall_in_resp_cycle", obs_wait, 1);
    step(0, 1, 1, 0, 0, 0);
    check("wr_accept_after_resp", obs_wait, 0);
    step(0, 1, 1, 0, 0, 0);
    check("wr_full_again", obs_wait, 1);
`ifdef KERNEL_SVM_CREDIT_LIMITER_STATS_EN
    check("wr_stall_total", wr_stall_cycles, 3);
`endif

    // Burst that fills the last slot must run to completion without throttling.
    do_reset(0, 0);
    for (int i = 0; i < 63; i++) step(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 8, 0, 0, 0);
      check("burst_no_throttle", obs_wait, 0);
    end
    step(0, 1, 1, 0, 0, 0);
    check("next_burst_throttled", obs_wait, 1);
    check("burst_no_err", protocol_err, 0);

    // Simultaneous read accept and return; idle lags the counter by one cycle.
    do_reset(0, 0);
    step(1, 0, 8, 0, 0, 0);
    step(1, 0, 2, 0, 0, 0);
    step(1, 0, 4, 0, 1, 0);
    check("rd_accept_with_return", obs_wait, 0);
    for (int i = 0; i < 13; i++) begin
      step(0, 0, 1, 0, 1, 0);
      check("idle_while_reads_out", idle, 0);
    end
    step(0, 0, 1, 0, 0, 0);
    check("idle_after_drain", idle, 1);
    check("drain_no_err", protocol_err, 0);

    // Protocol errors are sticky; a spurious response leaves the counter at zero.
    do_reset(0, 0);
    step(1, 1, 1, 0, 0, 0);
    check("err_rd_wr_same_cycle", protocol_err, 1);
    repeat (3) step(0, 0, 1, 0, 0, 0);
    check("err_sticky", protocol_err, 1);
    do_reset(0, 0);
    step(0, 0, 1, 0, 0, 1);
    check("err_spurious_wrresp", protocol_err, 1);
    step(0, 0, 1, 0, 0, 0);
    check("wr_cnt_saturates_idle", idle, 1);

    // Reset mid-burst with reads outstanding discards everything.
    do_reset(0, 0);
    step(1, 0, 16, 0, 0, 0);
    step(1, 0, 16, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 16, 0, 0, 0);
    do_reset(1, 1);
    check("midrst_idle", idle, 1);
    check("midrst_err", protocol_err, 0);
`ifdef KERNEL_SVM_CREDIT_LIMITER_STATS_EN
    check("midrst_rd_stall", rd_stall_cycles, 0);
    check("midrst_wr_stall", wr_stall_cycles, 0);
`endif
    step(1, 0, 4, 0, 0, 0);
    check("midrst_read_ok", obs_wait, 0);
    check("midrst_not_in_burst", protocol_err, 0);

    // Randomized traffic with periodic resets.
    for (int n = 0; n < 2000; n++) begin
      bit rd, wr, mw, rdv, wrv;
      int unsigned bc;
      if (n % 400 == 0) do_reset(1'($urandom), 1'($urandom));
      bc = $urandom_range(1, 16);
      if ($urandom_range(0, 149) == 0) bc = 0;
      if (mdl_left > 0) begin
        wr = $urandom_range(0, 3) != 0;
        rd = $urandom_range(0, 199) == 0;
      end else begin
        wr = $urandom_range(0, 2) == 0;
        rd = !wr && ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 199) == 0) rd = 1;
      end
      mw  = $urandom_range(0, 3) == 0;
      rdv = (mdl_rd > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 149) == 0);
      wrv = (mdl_wr > 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 149) == 0);
      step(rd, wr, bc, mw, rdv, wrv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kernel_svm_credit_limiter.md
# kernel_svm_credit_limiter

Host-clock-domain stage between the kernel SVM async clock-crossing shim and the Avalon-to-rd/wr split that feeds the kernel's USM virtual-address host-memory channel. Bounds the number of outstanding read beats and write bursts the kernel may have in flight toward VTP and host memory. Tracks write-burst boundaries so throttling occurs only at burst starts. Exposes an `idle` indication for kernel drain and fence logic, plus a sticky protocol-error flag.

## Interface
Parameters:
- ADDR_WIDTH, 48, byte address width
- DATA_WIDTH, 512, data bus width
- BURST_CNT_WIDTH, 5, burstcount width; MAX_BURST = 2^(BURST_CNT_WIDTH-1) = 16
- MAX_RD_BEATS, 256, read-beat credit limit; must be >= 2*MAX_BURST
- MAX_WR_BURSTS, 64, outstanding write-burst limit

Ports (clock and reset first):
- clk  in  1  host clock; single clock domain
- reset_n  in  1  synchronous, active-low reset
- s_address / m_address  in / out  ADDR_WIDTH  address, passed through
- s_read / m_read  in / out  1  read request
- s_write / m_write  in / out  1  write beat
- s_burstcount / m_burstcount  in / out  BURST_CNT_WIDTH  burst length, 1..MAX_BURST
- s_writedata / m_writedata  in / out  DATA_WIDTH  write data
- s_byteenable / m_byteenable  in / out  DATA_WIDTH/8  byte enables
- s_waitrequest / m_waitrequest  out / in  1  stall
- s_readdata / m_readdata  out / in  DATA_WIDTH  read data
- s_readdatavalid / m_readdatavalid  out / in  1  read beat valid
- s_writeresponsevalid / m_writeresponsevalid  out / in  1  one per write burst
- idle  out  1  no outstanding reads, no outstanding writes, not mid-burst
- protocol_err  out  1  sticky error flag

## Operation
State:
- rd_cnt: $clog2(MAX_RD_BEATS+1) bits
- wr_cnt: $clog2(MAX_WR_BURSTS+1) bits
- wr_beats_left: BURST_CNT_WIDTH bits
- FSM: WR_IDLE / WR_BURST

Throttle terms:
- rd_full = rd_cnt > MAX_RD_BEATS - MAX_BURST
- wr_full = (wr_cnt == MAX_WR_BURSTS)
- first_beat = (FSM == WR_IDLE)

Command path:
- blk = (s_read & rd_full) | (s_write & first_beat & wr_full)
- s_waitrequest = m_waitrequest | blk
- m_read = s_read & ~blk; m_write = s_write & ~blk
- Address, burstcount, data and byteenable pass through unchanged.

Accounting:
- Read accept (s_read & ~s_waitrequest): rd_cnt += s_burstcount.
- Each m_readdatavalid: rd_cnt -= 1. Simultaneous accept and return apply the net change in the same cycle.
- Write accept in WR_IDLE:
  - wr_cnt += 1.
  - If s_burstcount > 1: load wr_beats_left = s_burstcount-1 and go to WR_BURST.
- Write accept in WR_BURST: decrement wr_beats_left; at 1 -> 0, return to WR_IDLE. The limiter never stalls mid-burst.
- Each m_writeresponsevalid: wr_cnt -= 1.

Responses:
- readdata, readdatavalid and writeresponsevalid pass through combinationally with zero latency.

idle:
- idle = (rd_cnt == 0) & (wr_cnt == 0) & first_beat, registered.

protocol_err sets on any of:
- s_read & s_write in the same cycle
- s_burstcount == 0 on a request
- s_read while in WR_BURST
- m_readdatavalid with rd_cnt == 0
- m_writeresponsevalid with wr_cnt == 0

On an error event, the affected counter saturates at 0. Only reset clears protocol_err.

## Timing
- Reset values: rd_cnt = 0, wr_cnt = 0, FSM = WR_IDLE, idle = 1 the cycle after reset is released, protocol_err = 0, stall counters = 0.
- While reset_n is low, m_read and m_write are forced to 0 and s_waitrequest is forced to 1.
- Reset mid-burst or with reads outstanding discards all state. The whole channel is reset together.
- s_waitrequest depends combinationally on m_waitrequest, s_read, s_write and registered state. It does not depend on s_burstcount.
- Counter updates are visible the cycle after the accept or response. A throttle releases one cycle after the response that brings the counter under its limit.

## Configuration
- KERNEL_SVM_CREDIT_LIMITER_STATS_EN defined:
  - Adds output ports rd_stall_cycles [31:0] and wr_stall_cycles [31:0].
  - Each counts cycles in which blk stalls a read or write, respectively. Stalls caused only by m_waitrequest are not counted.
  - Counters saturate at 0xFFFFFFFF and clear on reset.
- Macro undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- 15 reads of burstcount 16 with no returns -> rd_cnt = 240 and the 16th read is accepted. A 17th read sees s_waitrequest = 1 until the first m_readdatavalid brings rd_cnt to 255; rd_cnt must be ≤ 240 before another read is accepted.
- 64 single-beat writes with no responses -> 65th write stalled. One m_writeresponsevalid -> accepted the cycle after the next; wr_cnt returns to 64.
- wr_cnt = 63, then an 8-beat burst is accepted -> wr_cnt = 64 after the first beat. All 8 beats pass with m_waitrequest = 0 and no limiter stalls; FSM returns to WR_IDLE after beat 8.
- Read accept (burstcount 4) in the same cycle as a returning m_readdatavalid with rd_cnt = 10 -> rd_cnt = 13. idle stays 0 until all beats return, then is 1 one cycle later.
- s_read and s_write asserted together -> protocol_err = 1 and stays set. Extra m_writeresponsevalid with wr_cnt = 0 -> wr_cnt stays 0.
- Reset pulse mid 16-beat write and with 32 reads outstanding -> all counters 0, FSM WR_IDLE, idle = 1. With STATS_EN defined, stall counters read 0.
